// File: rtl/program_loader.sv
// program_loader: boot-time loader in front of the CPU's 16x8 memory_module.
// Accepts a byte stream over valid/ready: a length header N, then N payload
// bytes, then optionally a checksum byte. Payload goes to addresses 0..N-1.
// cpu_run is raised once the load completes (and verifies).
// i_reset is asynchronous and active low.
// Optional feature macro: LOADER_CHECKSUM_EN adds the trailing checksum byte
// and its CHK state. Without it, the loader finishes after the Nth payload byte.
module program_loader #(
   parameter int ADDR_W  = 4,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 255
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_start,
   input  logic              i_in_valid,
   input  logic [DATA_W-1:0] i_in_data,
   output logic              o_in_ready,
   output logic [ADDR_W-1:0] o_mem_address,
   output logic              o_mem_write,
   output logic [DATA_W-1:0] o_mem_data,
   output logic              o_cpu_run,
   output logic              o_busy,
   output logic              o_error,
   output logic [ADDR_W:0]   o_byte_count
);

   localparam int DEPTH = 2 ** ADDR_W;
   // The timer only has to count up to TIMEOUT-1; keep one bit when the timeout is disabled.
   localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_DATA,
`ifdef LOADER_CHECKSUM_EN
      S_CHK,
`endif
      S_DONE,
      S_ERR
   } state_t;

   state_t            r_state;
   logic              r_in_ready;
   logic [ADDR_W-1:0] r_mem_address;
   logic              r_mem_write;
   logic [DATA_W-1:0] r_mem_data;
   logic              r_cpu_run;
   logic              r_busy;
   logic              r_error;
   logic [ADDR_W:0]   r_byte_count;
   logic [ADDR_W:0]   r_len;
   logic [TMR_W-1:0]  r_timer;
`ifdef LOADER_CHECKSUM_EN
   logic [DATA_W-1:0] r_csum;
`endif

   logic              w_hs;
   logic              w_len_bad;
   logic [ADDR_W:0]   w_cnt_nxt;
   logic              w_tmo;

   assign w_hs      = i_in_valid & r_in_ready;
   // Header must give 1..DEPTH bytes; anything else cannot fit or is meaningless.
   assign w_len_bad = (i_in_data == '0) || (i_in_data > DATA_W'(DEPTH));
   assign w_cnt_nxt = r_byte_count + 1'b1;
   // Idle cycle that would bring the timer up to TIMEOUT.
   assign w_tmo     = (TIMEOUT != 0) && (r_timer == TMR_LAST);

   assign o_in_ready    = r_in_ready;
   assign o_mem_address = r_mem_address;
   assign o_mem_write   = r_mem_write;
   assign o_mem_data    = r_mem_data;
   assign o_cpu_run     = r_cpu_run;
   assign o_busy        = r_busy;
   assign o_error       = r_error;
   assign o_byte_count  = r_byte_count;

   // Load sequencer: state, handshake, memory write strobe and status flags.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state       <= S_IDLE;
         r_in_ready    <= 1'b0;
         r_mem_address <= '0;
         r_mem_write   <= 1'b0;
         r_mem_data    <= '0;
         r_cpu_run     <= 1'b0;
         r_busy        <= 1'b0;
         r_error       <= 1'b0;
         r_byte_count  <= '0;
         r_len         <= '0;
         r_timer       <= '0;
`ifdef LOADER_CHECKSUM_EN
         r_csum        <= '0;
`endif
      end else begin
         // Write strobe is a one-cycle pulse per accepted payload byte.
         r_mem_write <= 1'b0;
         if (i_start) begin
            // Start wins over any handshake this cycle; memory is left untouched.
            r_state      <= S_HDR;
            r_in_ready   <= 1'b1;
            r_busy       <= 1'b1;
            r_error      <= 1'b0;
            r_cpu_run    <= 1'b0;
            r_byte_count <= '0;
            r_timer      <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_csum       <= '0;
`endif
         end else begin
            case (r_state)
               S_HDR: begin
                  if (w_hs) begin
                     r_timer <= '0;
                     if (w_len_bad) begin
                        r_state    <= S_ERR;
                        r_error    <= 1'b1;
                        r_busy     <= 1'b0;
                        r_in_ready <= 1'b0;
                     end else begin
                        r_len   <= i_in_data[ADDR_W:0];
                        r_state <= S_DATA;
                     end
                  end else if (w_tmo) begin
                     r_state    <= S_ERR;
                     r_error    <= 1'b1;
                     r_busy     <= 1'b0;
                     r_in_ready <= 1'b0;
                  end else begin
                     r_timer <= r_timer + TMR_W'(1);
                  end
               end
               S_DATA: begin
                  if (w_hs) begin
                     r_timer       <= '0;
                     r_mem_write   <= 1'b1;
                     r_mem_address <= r_byte_count[ADDR_W-1:0];
                     r_mem_data    <= i_in_data;
                     r_byte_count  <= w_cnt_nxt;
`ifdef LOADER_CHECKSUM_EN
                     r_csum        <= r_csum + i_in_data;
`endif
                     if (w_cnt_nxt == r_len) begin
`ifdef LOADER_CHECKSUM_EN
                        r_state    <= S_CHK;
`else
                        r_state    <= S_DONE;
                        r_cpu_run  <= 1'b1;
                        r_busy     <= 1'b0;
                        r_in_ready <= 1'b0;
`endif
                     end
                  end else if (w_tmo) begin
                     r_state    <= S_ERR;
                     r_error    <= 1'b1;
                     r_busy     <= 1'b0;
                     r_in_ready <= 1'b0;
                  end else begin
                     r_timer <= r_timer + TMR_W'(1);
                  end
               end
`ifdef LOADER_CHECKSUM_EN
               S_CHK: begin
                  if (w_hs) begin
                     r_busy     <= 1'b0;
                     r_in_ready <= 1'b0;
                     if (i_in_data == r_csum) begin
                        r_state   <= S_DONE;
                        r_cpu_run <= 1'b1;
                     end else begin
                        r_state <= S_ERR;
                        r_error <= 1'b1;
                     end
                  end
               end
`endif
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader (TIMEOUT overridden to 5).
// Works with or without LOADER_CHECKSUM_EN defined.
module tb_program_loader;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              in_valid = 1'b0;
   logic [DATA_W-1:0] in_data = '0;
   logic              in_ready;
   logic [ADDR_W-1:0] mem_address;
   logic              mem_write;
   logic [DATA_W-1:0] mem_data;
   logic              cpu_run;
   logic              busy;
   logic              error;
   logic [ADDR_W:0]   byte_count;

   int n_vec = 0;
   int n_err = 0;
   int wr_cnt = 0;

   program_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(5)) dut (
      .i_clk(clk), .i_reset(rst_n), .i_start(start),
      .i_in_valid(in_valid), .i_in_data(in_data), .o_in_ready(in_ready),
      .o_mem_address(mem_address), .o_mem_write(mem_write), .o_mem_data(mem_data),
      .o_cpu_run(cpu_run), .o_busy(busy), .o_error(error), .o_byte_count(byte_count)
   );

   always #5 clk = ~clk;

   // Count write strobes, sampled mid-cycle.
   always @(negedge clk) if (mem_write) wr_cnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one byte; returns at the negedge after the edge that takes it.
   task automatic put(input logic [7:0] b);
      in_valid = 1'b1;
      in_data  = b;
      @(negedge clk);
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_data  = '0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic check_wr(input string tag, input logic [3:0] a, input logic [7:0] d);
      check({tag, ".we"}, mem_write, 1);
      check({tag, ".addr"}, mem_address, a);
      check({tag, ".data"}, mem_data, d);
   endtask

   task automatic check_idle_outs(input string tag);
      check({tag, ".rdy"}, in_ready, 0);
      check({tag, ".we"}, mem_write, 0);
      check({tag, ".addr"}, mem_address, 0);
      check({tag, ".data"}, mem_data, 0);
      check({tag, ".run"}, cpu_run, 0);
      check({tag, ".busy"}, busy, 0);
      check({tag, ".err"}, error, 0);
      check({tag, ".cnt"}, byte_count, 0);
   endtask

   initial begin
      int w0;
      // Reset state
      repeat (2) @(negedge clk);
      check_idle_outs("rst");
      rst_n = 1'b1;
      @(negedge clk);

      // in_valid while not ready: ignored
      w0 = wr_cnt;
      put(8'h03); put(8'hA1);
      idle();
      check("ign.busy", busy, 0);
      check("ign.rdy", in_ready, 0);
      check("ign.wr", wr_cnt - w0, 0);

      // Normal load 03, A1, B2, C3 (+ checksum 16)
      pulse_start();
      check("ld.busy", busy, 1);
      check("ld.rdy", in_ready, 1);
      put(8'h03);
      check("ld.hdr_we", mem_write, 0);
      put(8'hA1); check_wr("ld.w0", 4'd0, 8'hA1);
      put(8'hB2); check_wr("ld.w1", 4'd1, 8'hB2);
      put(8'hC3); check_wr("ld.w2", 4'd2, 8'hC3);
`ifdef LOADER_CHECKSUM_EN
      check("ld.run_early", cpu_run, 0);
      put(8'h16);
      check("ld.chk_we", mem_write, 0);
`endif
      idle();
      check("ld.run", cpu_run, 1);
      check("ld.busy_done", busy, 0);
      check("ld.cnt", byte_count, 3);
      check("ld.rdy_done", in_ready, 0);
      check("ld.err", error, 0);
      @(negedge clk);
      check("ld.hold", cpu_run, 1);

`ifdef LOADER_CHECKSUM_EN
      // Bad checksum
      pulse_start();
      check("bad.run_drop", cpu_run, 0);
      put(8'h03); put(8'hA1); put(8'hB2); put(8'hC3); put(8'h17);
      idle();
      check("bad.err", error, 1);
      check("bad.run", cpu_run, 0);
      check("bad.busy", busy, 0);
`endif

      // Header 00 -> error, no write
      pulse_start();
      check("h0.run_drop", cpu_run, 0);
      w0 = wr_cnt;
      put(8'h00);
      idle();
      check("h0.err", error, 1);
      check("h0.rdy", in_ready, 0);
      check("h0.busy", busy, 0);
      @(negedge clk);
      check("h0.wr", wr_cnt - w0, 0);

      // Header 0x11 (17) -> error, no write
      pulse_start();
      check("h17.err_clr", error, 0);
      w0 = wr_cnt;
      put(8'h11);
      idle();
      check("h17.err", error, 1);
      check("h17.rdy", in_ready, 0);
      @(negedge clk);
      check("h17.wr", wr_cnt - w0, 0);

      // Full depth back-to-back: 16 bytes 00..0F
      pulse_start();
      put(8'h10);
      for (int i = 0; i < 16; i++) begin
         put(8'(i));
         check_wr($sformatf("fd.w%0d", i), 4'(i), 8'(i));
      end
      check("fd.cnt", byte_count, 16);
`ifdef LOADER_CHECKSUM_EN
      put(8'h78);
`endif
      idle();
      check("fd.run", cpu_run, 1);
      check("fd.err", error, 0);

      // Timeout: header 02, one byte, then 5 idle cycles
      pulse_start();
      put(8'h02);
      put(8'h55); check_wr("to.w0", 4'd0, 8'h55);
      idle();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("to.wait%0d", i), error, 0);
      end
      @(negedge clk);
      check("to.err", error, 1);
      check("to.busy", busy, 0);

      // start with a byte in the same cycle from ERR -> HDR, error clear
      start = 1'b1; in_valid = 1'b1; in_data = 8'h99;
      @(negedge clk);
      start = 1'b0; idle();
      check("rs.err", error, 0);
      check("rs.rdy", in_ready, 1);
      check("rs.busy", busy, 1);

      // start + handshake in DATA: byte dropped, restart at HDR
      put(8'h03);
      put(8'h44); check_wr("ab.w0", 4'd0, 8'h44);
      start = 1'b1; in_valid = 1'b1; in_data = 8'h77;
      @(negedge clk);
      start = 1'b0; idle();
      check("ab.we", mem_write, 0);
      check("ab.cnt", byte_count, 0);
      check("ab.busy", busy, 1);
      put(8'h01);
      put(8'h5A); check_wr("ab.w1", 4'd0, 8'h5A);
`ifdef LOADER_CHECKSUM_EN
      put(8'h5A);
`endif
      idle();
      check("ab.run", cpu_run, 1);
      check("ab.cnt1", byte_count, 1);

      // Reset mid-stream after 2 bytes
      pulse_start();
      put(8'h03); put(8'h11); put(8'h22);
      check("mr.we_pre", mem_write, 1);
      idle();
      #1 rst_n = 1'b0;
      #1;
      check_idle_outs("mr");
      w0 = wr_cnt;
      repeat (2) @(negedge clk);
      check("mr.wr", wr_cnt - w0, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("mr.busy_after", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time loader sitting directly upstream of the CPU's 16x8 memory_module.
- Accepts a byte stream (length header, payload, optional checksum) over a valid/ready handshake.
- Writes the payload into memory addresses 0..N-1, then releases the CPU via cpu_run.
- While loading, it owns the memory address/write/data lines and the CPU is held stopped.

Parameters:
ADDR_W, 4, memory address width; depth DEPTH = 2**ADDR_W (16)
DATA_W, 8, memory/stream word width
TIMEOUT, 255, max idle cycles between payload bytes before ERROR; 0 disables timeout

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  single-cycle pulse; begins or restarts a load
in_valid  input  1  stream byte valid
in_data  input  DATA_W  stream byte
in_ready  output  1  loader accepts in_data this cycle
mem_address  output  ADDR_W  write address to memory_module
mem_write  output  1  memory write strobe, one cycle per byte
mem_data  output  DATA_W  write data to memory_module
cpu_run  output  1  high = CPU may run (load complete and verified)
busy  output  1  load in progress
error  output  1  sticky load failure flag
byte_count  output  ADDR_W+1  payload bytes written so far

Behaviour:
- Reset (reset=0, async): state IDLE. All outputs 0: in_ready, mem_write, mem_address, mem_data, cpu_run, busy, error, byte_count. Internal length, checksum and timer are 0.
- A handshake occurs on a rising edge where in_valid=1 and in_ready=1. in_ready is a registered function of state: 1 in HDR, DATA and CHK; 0 otherwise.
- IDLE: start=1 -> HDR. Clears error, byte_count, checksum and cpu_run; busy=1.
- HDR: on handshake, in_data is the length N.
  - N==0 or N>DEPTH -> ERR.
  - Otherwise latch N -> DATA.
- DATA: on each handshake:
  - Next cycle: mem_write=1 for exactly one cycle, mem_address = byte_count[ADDR_W-1:0], mem_data = byte.
  - byte_count increments; checksum += byte, mod 2**DATA_W.
  - Latency from handshake edge to mem_write high: 1 cycle. Back-to-back bytes allowed, one per cycle.
  - After the Nth byte -> CHK (or DONE if the feature is compiled out).
  - Address never wraps: N<=DEPTH guarantees the last address is N-1.
- Timeout: in HDR and DATA, the timer increments on each cycle without a handshake and clears on a handshake. Timer reaching TIMEOUT (TIMEOUT!=0) -> ERR.
- CHK: on handshake, compare in_data with checksum. Equal -> DONE; unequal -> ERR.
- DONE: cpu_run=1, busy=0, in_ready=0. Holds until start or reset.
- ERR: error=1, cpu_run=0, busy=0, in_ready=0. Holds until start or reset.
- start while HDR, DATA or CHK: abort and restart at HDR. byte_count=0, checksum=0. Any mem_write already scheduled for that cycle still completes. Memory contents are not cleared.
- start in DONE or ERR: cpu_run and error drop on the next edge -> HDR.
- start and handshake in the same cycle: start wins and the byte is dropped.
- in_valid while in_ready=0: ignored, no state change.
- Reset mid-load: immediate abort; the partially written memory is left as-is; cpu_run=0.

Optional Feature:
LOADER_CHECKSUM_EN
- Defined: CHK state present; a trailing checksum byte is required; a mismatch -> ERR.
- Undefined: no CHK state; DATA goes straight to DONE after the Nth byte; checksum logic is removed. Streams are header plus payload only.

Test Plan:
- Reset mid-stream (reset=0 during DATA after 2 bytes) -> all outputs 0 immediately, state IDLE, no further mem_write.
- start; bytes 03, A1, B2, C3, checksum 16 (with _EN) -> mem writes (0,A1), (1,B2), (2,C3), each 1 cycle after its handshake. Then cpu_run=1, busy=0, byte_count=3.
- Same payload with checksum 17 -> error=1, cpu_run=0 after the CHK handshake. With the macro undefined, send 03, A1, B2, C3 only -> cpu_run=1.
- Header 00, then a separate run with header 11 (17) -> error=1, no mem_write, in_ready=0.
- start; header 10 (16); 16 bytes 00..0F sent back-to-back, in_valid held high -> 16 consecutive write cycles, addresses 0..15 with no wrap, byte_count=16.
- TIMEOUT=5; header 02, one byte, then in_valid=0 for 5 cycles -> error=1. Then start pulse with a new byte in the same cycle -> byte dropped, state HDR, error=0.
